// File: rtl/fft_stream_if.sv
// Serial complex-sample stream leaving the FFT output reader.
// The master drives one beat per valid/ready transfer, and the slave returns out_ready.
interface fft_stream_if #(
   parameter int DATA_W = 16,
   parameter int IDX_W  = 4
);
   logic [DATA_W-1:0] out_real;
   logic [DATA_W-1:0] out_imag;
   logic [IDX_W-1:0]  out_index;
   logic              out_valid;
   logic              out_ready;
   logic              out_last;

   modport master (
      output out_real, out_imag, out_index, out_valid, out_last,
      input  out_ready
   );

   modport slave (
      input  out_real, out_imag, out_index, out_valid, out_last,
      output out_ready
   );
endinterface

// File: rtl/fft_frame_streamer.sv
// Captures a full FFT frame from the last butterfly layer in one cycle.
// It then streams the frame one complex word per handshake beat, optionally in natural order from bit-reversed slots.
module fft_frame_streamer #(
   parameter int N_POINTS    = 16,
   parameter int DATA_W      = 16,
   parameter int BIT_REVERSE = 1,
   parameter int IDX_W       = $clog2(N_POINTS)
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         frame_ready,
   input  logic [N_POINTS*DATA_W-1:0]   in_real_bus,
   input  logic [N_POINTS*DATA_W-1:0]   in_imag_bus,
   fft_stream_if.master                 out_bus,
   output logic                         busy,
   output logic [7:0]                   drop_count
);

   typedef enum logic [0:0] {
      IDLE   = 1'b0,
      STREAM = 1'b1
   } state_t;

   state_t                       state_r, state_s;
   logic [IDX_W-1:0]             k_r, k_s;
   logic [7:0]                   drop_count_r, drop_s;
   logic [N_POINTS*DATA_W-1:0]   buf_real_r, buf_imag_r;
   logic                         capture_s;
   logic                         fire_s;
   logic                         final_s;
   logic [IDX_W-1:0]             slot_s;
   logic [DATA_W-1:0]            buf_re_a [N_POINTS];
   logic [DATA_W-1:0]            buf_im_a [N_POINTS];

   function automatic logic [IDX_W-1:0] bitrev(input logic [IDX_W-1:0] v);
      logic [IDX_W-1:0] r;
      for (int i = 0; i < IDX_W; i++) begin
         r[i] = v[IDX_W-1-i];
      end
      return r;
   endfunction

   for (genvar g = 0; g < N_POINTS; g++) begin : g_slot
      assign buf_re_a[g] = buf_real_r[g*DATA_W +: DATA_W];
      assign buf_im_a[g] = buf_imag_r[g*DATA_W +: DATA_W];
   end

   if (BIT_REVERSE != 0) begin : g_rev
      assign slot_s = bitrev(k_r);
   end else begin : g_nat
      assign slot_s = k_r;
   end

   // Next state, beat counter, capture strobe and drop counter.
   always_comb begin
      state_s   = state_r;
      k_s       = k_r;
      drop_s    = drop_count_r;
      capture_s = 1'b0;
      fire_s    = (state_r == STREAM) && out_bus.out_ready;
      final_s   = fire_s && (k_r == IDX_W'(N_POINTS - 1));
      case (state_r)
         IDLE: begin
            if (frame_ready) begin
               capture_s = 1'b1;
               k_s       = {IDX_W{1'b0}};
               state_s   = STREAM;
            end else begin
               state_s   = IDLE;
            end
         end
         STREAM: begin
            if (final_s) begin
               // A frame arriving on the last transfer chains straight in without a bubble.
               k_s = {IDX_W{1'b0}};
               if (frame_ready) begin
                  capture_s = 1'b1;
                  state_s   = STREAM;
               end else begin
                  state_s   = IDLE;
               end
            end else begin
               if (fire_s) begin
                  k_s = k_r + IDX_W'(1);
               end else begin
                  k_s = k_r;
               end
               if (frame_ready && (drop_count_r != 8'd255)) begin
                  drop_s = drop_count_r + 8'd1;
               end else begin
                  drop_s = drop_count_r;
               end
            end
         end
         default: begin
            state_s = IDLE;
            k_s     = {IDX_W{1'b0}};
         end
      endcase
   end

   // State, counters and frame buffer registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r      <= IDLE;
         k_r          <= {IDX_W{1'b0}};
         drop_count_r <= 8'd0;
         buf_real_r   <= {(N_POINTS*DATA_W){1'b0}};
         buf_imag_r   <= {(N_POINTS*DATA_W){1'b0}};
      end else begin
         state_r      <= state_s;
         k_r          <= k_s;
         drop_count_r <= drop_s;
         if (capture_s) begin
            buf_real_r <= in_real_bus;
            buf_imag_r <= in_imag_bus;
         end
      end
   end

   assign out_bus.out_valid = (state_r == STREAM);
   assign out_bus.out_index = k_r;
   assign out_bus.out_last  = (state_r == STREAM) && (k_r == IDX_W'(N_POINTS - 1));
   assign out_bus.out_real  = buf_re_a[slot_s];
   assign out_bus.out_imag  = buf_im_a[slot_s];
   assign busy              = (state_r == STREAM);
   assign drop_count        = drop_count_r;

endmodule

// File: tb/tb_fft_frame_streamer.sv
// Self-checking bench for fft_frame_streamer: natural-order and bit-reversed instances share one stimulus.
// Both instances are checked every cycle against a frame-level reference model, plus directed vectors and sequences.
module tb_fft_frame_streamer;

   localparam int N  = 16;
   localparam int W  = 16;
   localparam int IW = 4;

   logic           clk;
   logic           rst;
   logic           frame_ready;
   logic           out_ready;
   logic [N*W-1:0] in_real_bus;
   logic [N*W-1:0] in_imag_bus;
   logic           busy0, busy1;
   logic [7:0]     drop0, drop1;

   fft_stream_if #(.DATA_W(W), .IDX_W(IW)) s0 ();
   fft_stream_if #(.DATA_W(W), .IDX_W(IW)) s1 ();
   assign s0.out_ready = out_ready;
   assign s1.out_ready = out_ready;

   fft_frame_streamer #(.N_POINTS(N), .DATA_W(W), .BIT_REVERSE(0)) dut_nat (
      .clk(clk), .rst(rst), .frame_ready(frame_ready),
      .in_real_bus(in_real_bus), .in_imag_bus(in_imag_bus),
      .out_bus(s0), .busy(busy0), .drop_count(drop0)
   );

   fft_frame_streamer #(.N_POINTS(N), .DATA_W(W), .BIT_REVERSE(1)) dut_rev (
      .clk(clk), .rst(rst), .frame_ready(frame_ready),
      .in_real_bus(in_real_bus), .in_imag_bus(in_imag_bus),
      .out_bus(s1), .busy(busy1), .drop_count(drop1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: the frame currently held, the beat position within it and the lost-frame tally.
   logic         m_active;
   int           m_k;
   int           m_drops;
   logic [W-1:0] m_re [N];
   logic [W-1:0] m_im [N];

   typedef struct {
      logic fr;
      logic rdy;
      logic exp_valid;
      int   exp_idx;
      logic exp_last;
      int   exp_r0;
      int   exp_r1;
   } vec_t;
   vec_t vt[$];

   int brtab [N] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int rev(input int k);
      int r = 0;
      for (int b = 0; b < IW; b++) begin
         if (((k >> b) & 1) != 0) r = r | (1 << (IW - 1 - b));
      end
      return r;
   endfunction

   task automatic model_capture();
      for (int i = 0; i < N; i++) begin
         m_re[i] = in_real_bus[i*W +: W];
         m_im[i] = in_imag_bus[i*W +: W];
      end
   endtask

   task automatic model_step(input logic r, input logic fr, input logic rdy);
      if (r) begin
         m_active = 1'b0;
         m_k      = 0;
         m_drops  = 0;
         for (int i = 0; i < N; i++) begin
            m_re[i] = '0;
            m_im[i] = '0;
         end
      end else if (!m_active) begin
         if (fr) begin
            model_capture();
            m_active = 1'b1;
            m_k      = 0;
         end
      end else if (rdy && m_k == N - 1) begin
         m_k = 0;
         if (fr) model_capture();
         else m_active = 1'b0;
      end else begin
         if (fr && m_drops < 255) m_drops++;
         if (rdy) m_k++;
      end
   endtask

   task automatic check_model();
      chk("m_valid_nat", s0.out_valid, m_active);
      chk("m_valid_rev", s1.out_valid, m_active);
      chk("m_busy_nat", busy0, m_active);
      chk("m_busy_rev", busy1, m_active);
      chk("m_drop_nat", drop0, m_drops);
      chk("m_drop_rev", drop1, m_drops);
      chk("m_last_nat", s0.out_last, m_active && m_k == N - 1);
      chk("m_last_rev", s1.out_last, m_active && m_k == N - 1);
      if (m_active) begin
         chk("m_idx_nat", s0.out_index, m_k);
         chk("m_idx_rev", s1.out_index, m_k);
         chk("m_re_nat", s0.out_real, m_re[m_k]);
         chk("m_im_nat", s0.out_imag, m_im[m_k]);
         chk("m_re_rev", s1.out_real, m_re[rev(m_k)]);
         chk("m_im_rev", s1.out_imag, m_im[rev(m_k)]);
      end
   endtask

   // One clock: drive inputs, advance the model, sample just after the edge and compare.
   task automatic cycle(input logic r, input logic fr, input logic rdy);
      rst         = r;
      frame_ready = fr;
      out_ready   = rdy;
      model_step(r, fr, rdy);
      @(posedge clk);
      #1;
      check_model();
   endtask

   task automatic set_bus(input int base_re, input int base_im);
      for (int i = 0; i < N; i++) begin
         in_real_bus[i*W +: W] = W'(base_re + i);
         in_imag_bus[i*W +: W] = W'(base_im + i);
      end
   endtask

   task automatic set_bus_rand();
      for (int i = 0; i < N; i++) begin
         in_real_bus[i*W +: W] = W'($urandom);
         in_imag_bus[i*W +: W] = W'($urandom);
      end
   endtask

   task automatic add_vec(input logic fr, input logic rdy, input logic v, input int idx,
                          input logic last, input int r0, input int r1);
      vec_t e;
      e.fr = fr; e.rdy = rdy; e.exp_valid = v; e.exp_idx = idx;
      e.exp_last = last; e.exp_r0 = r0; e.exp_r1 = r1;
      vt.push_back(e);
   endtask

   initial begin
      int   exp_k;
      logic rdy;

      m_active = 1'b0; m_k = 0; m_drops = 0;
      for (int i = 0; i < N; i++) begin m_re[i] = '0; m_im[i] = '0; end

      // Captured beat shown first, beats 1..15 with a stall held on beat 3, then back to idle.
      add_vec(1'b1, 1'b1, 1'b1, 0, 1'b0, 'h100, 'h100);
      for (int i = 1; i < N; i++) begin
         add_vec(1'b0, 1'b1, 1'b1, i, (i == N - 1), 'h100 + i, 'h100 + brtab[i]);
         if (i == 3) add_vec(1'b0, 1'b0, 1'b1, 3, 1'b0, 'h103, 'h100 + brtab[3]);
      end
      add_vec(1'b0, 1'b1, 1'b0, 0, 1'b0, 0, 0);

      // Reset state.
      set_bus('h100, 'h200);
      cycle(1'b1, 1'b0, 1'b0);
      cycle(1'b1, 1'b0, 1'b0);
      chk("rst_valid", s0.out_valid, 1'b0);
      chk("rst_last", s0.out_last, 1'b0);
      chk("rst_busy", busy1, 1'b0);
      chk("rst_drop", drop0, 8'd0);
      chk("rst_real", s0.out_real, 16'h0000);
      chk("rst_imag", s1.out_imag, 16'h0000);
      chk("rst_index", s1.out_index, 4'd0);
      for (int c = 0; c < 8; c++) cycle(1'b0, 1'b0, 1'b1);

      // Basic and bit-reversed streaming from the vector table.
      foreach (vt[j]) begin
         cycle(1'b0, vt[j].fr, vt[j].rdy);
         chk("tv_valid", s0.out_valid, vt[j].exp_valid);
         chk("tv_busy", busy0, vt[j].exp_valid);
         if (vt[j].exp_valid) begin
            chk("tv_idx_nat", s0.out_index, vt[j].exp_idx);
            chk("tv_idx_rev", s1.out_index, vt[j].exp_idx);
            chk("tv_last", s1.out_last, vt[j].exp_last);
            chk("tv_re_nat", s0.out_real, vt[j].exp_r0);
            chk("tv_re_rev", s1.out_real, vt[j].exp_r1);
            chk("tv_im_nat", s0.out_imag, vt[j].exp_r0 + 'h100);
            chk("tv_im_rev", s1.out_imag, vt[j].exp_r1 + 'h100);
         end
      end

      // Backpressure: 4-cycle stalls on beats 3 and 7, 24 cycles for 16 transfers.
      cycle(1'b0, 1'b1, 1'b1);
      exp_k = 0;
      for (int c = 0; c < 24; c++) begin
         chk("bp_idx", s0.out_index, exp_k);
         chk("bp_real", s0.out_real, 'h100 + exp_k);
         chk("bp_last", s0.out_last, exp_k == N - 1);
         chk("bp_valid", s0.out_valid, 1'b1);
         rdy = !((c >= 3 && c <= 6) || (c >= 11 && c <= 14));
         cycle(1'b0, 1'b0, rdy);
         if (rdy) exp_k++;
      end
      chk("bp_done_valid", s0.out_valid, 1'b0);
      chk("bp_done_busy", busy0, 1'b0);

      // Back-to-back frames: the new frame arrives with the final transfer.
      cycle(1'b0, 1'b1, 1'b1);
      for (int c = 0; c < N - 1; c++) cycle(1'b0, 1'b0, 1'b1);
      set_bus('hA00, 'hB00);
      cycle(1'b0, 1'b1, 1'b1);
      chk("b2b_valid", s0.out_valid, 1'b1);
      chk("b2b_idx", s0.out_index, 4'd0);
      chk("b2b_real", s0.out_real, 16'h0A00);
      chk("b2b_drop", drop0, 8'd0);
      for (int c = 0; c < N; c++) cycle(1'b0, 1'b0, 1'b1);

      // Collision at beat 5 is dropped, current frame continues untouched.
      set_bus('h100, 'h200);
      cycle(1'b0, 1'b1, 1'b1);
      for (int c = 0; c < 5; c++) cycle(1'b0, 1'b0, 1'b1);
      set_bus('hB00, 'hC00);
      cycle(1'b0, 1'b1, 1'b1);
      chk("col_drop", drop0, 8'd1);
      for (int k = 6; k < N; k++) begin
         chk("col_real", s0.out_real, 'h100 + k);
         chk("col_idx", s0.out_index, k);
         cycle(1'b0, 1'b0, 1'b1);
      end
      chk("col_end_valid", s0.out_valid, 1'b0);

      // Saturation: 300 collisions while a frame is stalled on beat 0.
      cycle(1'b0, 1'b1, 1'b0);
      for (int p = 0; p < 300; p++) begin
         cycle(1'b0, 1'b1, 1'b0);
         cycle(1'b0, 1'b0, 1'b0);
      end
      chk("sat_drop", drop1, 8'd255);
      chk("sat_idx", s1.out_index, 4'd0);

      // Reset at beat 8 aborts the frame; next frame restarts at beat 0.
      for (int c = 0; c < 8; c++) cycle(1'b0, 1'b0, 1'b1);
      cycle(1'b1, 1'b0, 1'b1);
      chk("rm_valid", s0.out_valid, 1'b0);
      chk("rm_drop", drop0, 8'd0);
      chk("rm_real", s0.out_real, 16'h0000);
      set_bus('hC00, 'hD00);
      cycle(1'b0, 1'b1, 1'b1);
      chk("rm_restart_idx", s0.out_index, 4'd0);
      chk("rm_restart_real", s0.out_real, 16'h0C00);
      chk("rm_restart_imag", s1.out_imag, 16'h0D00);

      // Randomized traffic against the reference model.
      for (int c = 0; c < 3000; c++) begin
         set_bus_rand();
         cycle(($urandom_range(0, 599) == 0), ($urandom_range(0, 11) == 0),
               ($urandom_range(0, 9) < 7));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/fft_frame_streamer.md
Name: fft_frame_streamer

Overview:
Output-side reader for the parallel butterfly FFT array. When the final butterfly layer asserts its ready flag, this block captures one complete frame of N complex results in a single cycle. It then streams the frame out one complex word per beat over a valid/ready handshake, optionally undoing bit-reversed ordering so results leave in natural frequency order. It sits between the last butterfly layer and any serial consumer, such as a magnitude unit, UART bridge or memory writer.

Parameters:
N_POINTS, 16, frame length in complex samples; must be a power of 2, range 4..64.
DATA_W, 16, width of each real and imaginary component.
BIT_REVERSE, 1, 1 = output slot bitrev(k) on beat k; 0 = output slot k on beat k.
IDX_W, $clog2(N_POINTS), width of the index counter.

Ports:
clk  input  1  system clock; all logic on the rising edge.
rst  input  1  synchronous, active-high reset.
frame_ready  input  1  one-cycle pulse from the final butterfly layer ready flag (AND of the layer's per-unit flags).
in_real_bus  input  N_POINTS*DATA_W  packed real results; slot i is bits [i*DATA_W +: DATA_W].
in_imag_bus  input  N_POINTS*DATA_W  packed imaginary results, same packing as in_real_bus.
out_real  output  DATA_W  real component of the current beat.
out_imag  output  DATA_W  imaginary component of the current beat.
out_index  output  IDX_W  natural-order beat index k (0..N_POINTS-1).
out_valid  output  1  beat available.
out_ready  input  1  consumer accepts the beat.
out_last  output  1  high with the beat where k = N_POINTS-1.
busy  output  1  high whenever state = STREAM.
drop_count  output  8  number of frames lost; saturates at 255.

Behaviour:
- Reset: state = IDLE, k = 0, out_valid = 0, out_last = 0, busy = 0, drop_count = 0, out_real = out_imag = out_index = 0. The frame buffer is cleared to 0.
- Reset mid-stream aborts the frame immediately. There is no partial flush, and out_valid is 0 on the cycle after rst is sampled high.
- Frame buffer: registered copy of both buses, 2*N_POINTS*DATA_W flops. It is written only on a capture event.
- State IDLE:
  - If frame_ready = 1: capture both buses, set k = 0, go to STREAM.
  - Otherwise remain in IDLE with out_valid = 0.
- State STREAM:
  - out_valid = 1 and busy = 1.
  - out_index = k.
  - out_real/out_imag = buffer slot s, where s = bitrev_IDX_W(k) if BIT_REVERSE else k.
  - out_last = (k == N_POINTS-1).
- Latency: frame_ready sampled at edge t gives out_valid = 1 with k = 0 after edge t, i.e. 1 cycle.
- Handshake:
  - A beat transfers on any edge where out_valid & out_ready = 1; k then increments by 1.
  - While out_valid & !out_ready, out_real, out_imag, out_index and out_last hold stable.
  - out_valid never drops mid-frame.
  - Outputs are registered or driven directly from registers plus the buffer mux. There is no combinational path from out_ready to out_valid.
- Final beat (k = N_POINTS-1 transfers):
  - frame_ready = 0 on the same edge: go to IDLE, k = 0.
  - frame_ready = 1 on the same edge: capture the new frame, k = 0, remain in STREAM. Back-to-back frames therefore stream with no bubble.
- Frame collision: frame_ready = 1 while in STREAM, on any edge other than a final-beat transfer:
  - The new frame is discarded and the buffer is untouched.
  - drop_count increments by 1 unless it is already 255.
  - The current frame continues unchanged.
- Arithmetic: no scaling or rounding; data passes through bit-exact. The k counter wraps only through the explicit final-beat rule.
- Throughput: at most 1 beat per cycle; with out_ready held high a frame takes exactly N_POINTS cycles.

Test Plan:
1. Basic stream (BIT_REVERSE = 0, N = 16):
   - Stimulus: reset, then in slot i set real = 0x0100+i and imag = 0x0200+i; pulse frame_ready at cycle 10; hold out_ready = 1.
   - Required: out_valid high on cycles 11..26 with real 0x0100..0x010F; out_last only on cycle 26; busy low at cycle 27.
2. Bit reversal (BIT_REVERSE = 1, same data as test 1):
   - Required beat sequence of real values: 0x0100, 0x0108, 0x0104, 0x010C, 0x0102, …, 0x010F.
   - Required out_index: 0..15 in order.
3. Backpressure:
   - Stimulus: deassert out_ready during beats 3 and 7 for 4 cycles each.
   - Required: data, out_index and out_last stable throughout each stall; frame completes after 16 transfers and 24 cycles; no beat duplicated or skipped.
4. Back-to-back frames:
   - Stimulus: pulse frame_ready on the same edge as the final transfer, with second-frame real = 0x0A00+i.
   - Required: next cycle shows k = 0, real 0x0A00, out_valid still 1; drop_count = 0.
5. Collision and saturation:
   - Stimulus: pulse frame_ready at beat 5 of a frame.
   - Required: drop_count = 1 and first-frame data uninterrupted.
   - Stimulus: 300 collision pulses.
   - Required: drop_count = 255.
6. Reset mid-operation:
   - Stimulus: assert rst at beat 8 for 1 cycle.
   - Required: out_valid = 0 and drop_count = 0 on the next cycle; a following frame_ready restarts at k = 0 with new data.
